request_unit: RTL and testbench
===============================

Name: request_unit

Overview:
- Memory-request sequencer between the control unit and the memory arbiter of the single-cycle MIPS datapath.
- Consumes the control unit's iREN/dREN/dWEN/halt decode and converts it into held, handshaked memory enables.
- Generates the PC-advance strobe and the sticky halt.
- Keeps retired-instruction and data-access counters plus a data-access watchdog flag for debug.

Parameters:
- CNT_W, 32, width of the saturating performance counters.
- MAX_WAIT, 64, number of DATA-state cycles without dhit before mem_timeout is set.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction memory handshake; imemload is valid this cycle.
- dhit  in  1  data memory handshake; load/store completes this cycle.
- iREN  in  1  instruction read request from control unit.
- dREN  in  1  data read request from control unit (lw).
- dWEN  in  1  data write request from control unit (sw).
- halt_in  in  1  halt decode from control unit.
- imemREN  out  1  instruction memory read enable.
- dmemREN  out  1  data memory read enable, held until dhit.
- dmemWEN  out  1  data memory write enable, held until dhit.
- pc_en  out  1  PC/register-file commit strobe for the current instruction.
- halt  out  1  sticky halt to datapath/system.
- instr_cnt  out  CNT_W  retired instruction count.
- dmem_cnt  out  CNT_W  completed data accesses.
- mem_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, nRST low): state=FETCH; dmemREN=0, dmemWEN=0, halt=0, instr_cnt=0, dmem_cnt=0, mem_timeout=0, wait counter=0. Because imemREN is Mealy, it reads 1 during reset.
- States: FETCH, DATA, HALTED (enum reqstate_t).
- FETCH:
  - imemREN=iREN.
  - ihit & halt_in -> HALTED next cycle. halt registers to 1, pc_en=0, instr_cnt+1. halt_in has priority over dREN/dWEN.
  - ihit & (dREN|dWEN) & ~halt_in -> DATA. Register dmemREN<=dREN and dmemWEN<=dWEN; if both are set, dmemWEN wins and dmemREN=0. pc_en=0. Wait counter cleared.
  - ihit & no mem op & ~halt_in: stay in FETCH, pc_en=1 combinationally in the same cycle, instr_cnt+1.
  - ~ihit: hold, pc_en=0.
- DATA:
  - imemREN=0; dmemREN/dmemWEN held stable; ihit ignored.
  - dhit: clear dmemREN/dmemWEN on the edge, pc_en=1 that cycle, instr_cnt+1, dmem_cnt+1, -> FETCH.
  - No dhit: wait counter +1. When it reaches MAX_WAIT, set mem_timeout (sticky until reset). Remain in DATA; never abort the access.
- HALTED: imemREN=dmemREN=dmemWEN=pc_en=0, halt=1. Absorbing state, exit only by reset. ihit/dhit ignored.
- Timing: pc_en is Mealy, zero latency from hit. All other outputs except imemREN are registered. An lw/sw takes at least 2 cycles: ihit cycle, then the dhit cycle.
- Counters: saturate at all-ones, no wrap. A simultaneous instr/dmem increment is legal.
- Reset mid-DATA: enables drop immediately (async). The memory side must tolerate an abandoned access.
- Wait counter is $clog2(MAX_WAIT+1) bits and saturates at MAX_WAIT.

Decomposition:
- Add reqstate_t enum to cpu_types_pkg.
- Watchdog and counter widths stay local parameters.
- Sub-module sat_counter (parameterised width, inputs inc and clear, saturating). Instantiated for instr_cnt, dmem_cnt and the wait counter.

Test Plan:
- Reset then 3 non-memory instrs with ihit=1 each cycle -> pc_en=1 for 3 cycles, instr_cnt=3, dmem_cnt=0, dmemREN/WEN stay 0.
- lw (dREN=1) with ihit, dhit delayed 4 cycles -> dmemREN=1 for exactly 5 cycles, imemREN=0 during DATA, single pc_en pulse on the dhit cycle, dmem_cnt=1.
- sw with dREN=dWEN=1 both asserted -> dmemWEN=1, dmemREN=0, cleared on the cycle after dhit.
- halt_in=1 with dWEN=1 on ihit -> HALTED, halt=1 sticky, no dmemWEN. Further ihit/dhit pulses do not change counters.
- MAX_WAIT=4, lw with dhit withheld 10 cycles -> mem_timeout rises after 4 DATA cycles and stays 1 after dhit completes the access.
- Assert nRST low mid-DATA -> dmemREN falls asynchronously, all counters 0, state FETCH after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Holds the request-unit sequencer state encoding so that other units
// (and debug logic) can decode the sequencer state consistently.
package cpu_types_pkg;

    // FETCH  : waiting on the instruction fetch handshake
    // DATA   : a load/store is outstanding, enables held until dhit
    // HALTED : absorbing state, left only through reset
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } reqstate_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   CLK, nRST : clock / async active-low reset (count resets to 0)
//   clear     : synchronous clear, wins over inc
//   inc       : add one unless already at MAX
//   count     : current value
module sat_counter #(
    parameter int            W   = 8,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (inc && (count_q != MAX))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer between the control unit and the memory arbiter.
// Turns the control unit's per-instruction decode into held, handshaked
// memory enables, produces the PC commit strobe and a sticky halt, and keeps
// debug counters plus a data-access watchdog.
// Ports:
//   CLK, nRST          : clock / async active-low reset
//   ihit, dhit         : instruction / data memory handshakes
//   iREN, dREN, dWEN   : control-unit requests
//   halt_in            : halt decode
//   imemREN            : instruction read enable (combinational, FETCH only)
//   dmemREN, dmemWEN   : registered data enables, held until dhit
//   pc_en              : combinational commit strobe, same cycle as the hit
//   halt               : sticky halt
//   instr_cnt, dmem_cnt: saturating retired-instruction / data-access counts
//   mem_timeout        : sticky flag, a data access waited MAX_WAIT cycles
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             iREN,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt_in,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] dmem_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    reqstate_t   state_q, state_d;
    logic        dmemREN_q, dmemREN_d;
    logic        dmemWEN_q, dmemWEN_d;
    logic        halt_q, halt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        instr_inc, dmem_inc, wait_inc, wait_clr;
    logic [WAIT_W-1:0] wait_cnt;
    logic        mem_op;

    assign mem_op = dREN | dWEN;

    always_comb begin
        state_d       = state_q;
        dmemREN_d     = dmemREN_q;
        dmemWEN_d     = dmemWEN_q;
        halt_d        = halt_q;
        mem_timeout_d = mem_timeout_q;
        imemREN       = 1'b0;
        pc_en         = 1'b0;
        instr_inc     = 1'b0;
        dmem_inc      = 1'b0;
        wait_inc      = 1'b0;
        wait_clr      = 1'b0;

        case (state_q)
            FETCH: begin
                imemREN = iREN;
                if (ihit) begin
                    if (halt_in) begin
                        // Halt retires the instruction but never issues its
                        // memory op and never advances the PC.
                        state_d   = HALTED;
                        halt_d    = 1'b1;
                        instr_inc = 1'b1;
                    end else if (mem_op) begin
                        state_d   = DATA;
                        dmemWEN_d = dWEN;
                        dmemREN_d = dREN & ~dWEN;  // write wins a double request
                        wait_clr  = 1'b1;
                    end else begin
                        pc_en     = 1'b1;
                        instr_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    dmemREN_d = 1'b0;
                    dmemWEN_d = 1'b0;
                    pc_en     = 1'b1;
                    instr_inc = 1'b1;
                    dmem_inc  = 1'b1;
                    state_d   = FETCH;
                end else begin
                    wait_inc = 1'b1;
                    // Raise the flag on the same edge the wait count lands on
                    // MAX_WAIT; the access itself is never abandoned.
                    if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
                        mem_timeout_d = 1'b1;
                end
            end
            HALTED: begin
                dmemREN_d = 1'b0;
                dmemWEN_d = 1'b0;
                halt_d    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= FETCH;
            dmemREN_q     <= 1'b0;
            dmemWEN_q     <= 1'b0;
            halt_q        <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dmemREN_q     <= dmemREN_d;
            dmemWEN_q     <= dmemWEN_d;
            halt_q        <= halt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (instr_inc),
        .count (instr_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dmem_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (1'b0),
        .inc   (dmem_inc),
        .count (dmem_cnt)
    );

    sat_counter #(.W(WAIT_W), .MAX(WAIT_W'(MAX_WAIT))) u_wait_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (wait_clr),
        .inc   (wait_inc),
        .count (wait_cnt)
    );

    assign dmemREN     = dmemREN_q;
    assign dmemWEN     = dmemWEN_q;
    assign halt        = halt_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_request_unit.sv
module tb_request_unit;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, dhit = 1'b0, iREN = 1'b1, dREN = 1'b0, dWEN = 1'b0, halt_in = 1'b0;
    logic imemREN, dmemREN, dmemWEN, pc_en, halt, mem_timeout;
    logic [CNT_W-1:0] instr_cnt, dmem_cnt;

    request_unit #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .iREN(iREN),
        .dREN(dREN), .dWEN(dWEN), .halt_in(halt_in), .imemREN(imemREN),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .pc_en(pc_en), .halt(halt),
        .instr_cnt(instr_cnt), .dmem_cnt(dmem_cnt), .mem_timeout(mem_timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit imem, dren, dwen, pc, hlt, to;
        int instr, dmem;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;

    // Reference model: an outstanding access kind, a halted flag, plain
    // integer event counts and a count of stalled cycles for the access.
    int m_pend;      // 0 none, 1 read, 2 write
    bit m_halted;
    int m_instr, m_dmem, m_waits;
    bit m_to;

    function automatic int sat(int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_halted = 0; m_instr = 0; m_dmem = 0; m_waits = 0; m_to = 0;
    endtask

    // One cycle of stimulus: drive, predict this cycle's outputs, then
    // advance the model across the coming rising edge.
    task automatic step(bit ih, bit dh, bit ir, bit dr, bit dw, bit hi);
        exp_t e;
        @(negedge CLK);
        ihit = ih; dhit = dh; iREN = ir; dREN = dr; dWEN = dw; halt_in = hi;
        #1;
        e.imem  = (!m_halted && m_pend == 0) ? ir : 1'b0;
        e.dren  = (m_pend == 1);
        e.dwen  = (m_pend == 2);
        e.pc    = !m_halted && ((m_pend != 0) ? dh : (ih && !hi && !(dr || dw)));
        e.hlt   = m_halted;
        e.to    = m_to;
        e.instr = sat(m_instr);
        e.dmem  = sat(m_dmem);
        sb.push_back(e);

        if (!m_halted) begin
            if (m_pend != 0) begin
                if (dh) begin
                    m_pend = 0; m_instr++; m_dmem++;
                end else begin
                    m_waits++;
                    if (m_waits >= MAX_WAIT) m_to = 1;
                end
            end else if (ih) begin
                if (hi) begin
                    m_halted = 1; m_instr++;
                end else if (dw) begin
                    m_pend = 2; m_waits = 0;
                end else if (dr) begin
                    m_pend = 1; m_waits = 0;
                end else begin
                    m_instr++;
                end
            end
        end
    endtask

    // Asynchronous reset in mid-cycle, checked immediately, released away
    // from any clock edge with the handshakes idle.
    task automatic reset_mid();
        @(negedge CLK);
        #3;
        ihit = 0; dhit = 0; iREN = 1; dREN = 0; dWEN = 0; halt_in = 0;
        nRST = 0;
        #1;
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_dmemWEN", dmemWEN, 0);
        chk("rst_imemREN", imemREN, 1);
        chk("rst_halt", halt, 0);
        chk("rst_instr_cnt", instr_cnt, 0);
        chk("rst_dmem_cnt", dmem_cnt, 0);
        chk("rst_timeout", mem_timeout, 0);
        model_reset();
        @(negedge CLK);
        #3;
        nRST = 1;
    endtask

    // Monitor: compare the expected record for every cycle the DUT presents.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("imemREN", imemREN, mon_e.imem);
                chk("dmemREN", dmemREN, mon_e.dren);
                chk("dmemWEN", dmemWEN, mon_e.dwen);
                chk("pc_en", pc_en, mon_e.pc);
                chk("halt", halt, mon_e.hlt);
                chk("mem_timeout", mem_timeout, mon_e.to);
                chk("instr_cnt", instr_cnt, mon_e.instr);
                chk("dmem_cnt", dmem_cnt, mon_e.dmem);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        reset_mid();

        // three plain instructions
        repeat (3) step(1, 0, 1, 0, 0, 0);
        // lw, dhit four cycles late (ihit ignored while waiting)
        step(1, 0, 1, 1, 0, 0);
        repeat (4) step(1, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        // double request becomes a write
        step(1, 0, 1, 1, 1, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        // watchdog: dhit withheld ten cycles
        step(1, 0, 1, 1, 0, 0);
        repeat (10) step(0, 0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        repeat (2) step(1, 0, 1, 0, 0, 0);
        // reset in the middle of a load
        step(1, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        reset_mid();
        step(1, 0, 1, 0, 0, 0);
        // halt beats a write; later hits are ignored
        step(1, 0, 1, 0, 1, 1);
        repeat (6) step(1, 1, 1, 1, 1, 0);
        // counter saturation
        reset_mid();
        repeat (20) step(1, 0, 1, 0, 0, 0);
        repeat (20) begin
            step(1, 0, 1, 1, 0, 0);
            step(0, 1, 1, 0, 0, 0);
        end

        // randomized episodes
        for (int ep = 0; ep < 4; ep++) begin
            reset_mid();
            for (int c = 0; c < 150; c++)
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        end

        @(negedge CLK);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
